// File: rtl/shifter_cmd_driver_if.sv
// Command bus between the driver and the shifter under exercise.
// The driver issues data/control/valid; the shifter returns its operation counter.
interface shifter_cmd_driver_if;
  logic [3:0] data_in;
  logic [2:0] control;
  logic       valid;
  logic [7:0] counter_in;

  modport master (
    output data_in,
    output control,
    output valid,
    input  counter_in
  );

  modport slave (
    input  data_in,
    input  control,
    input  valid,
    output counter_in
  );
endinterface

// File: rtl/shifter_cmd_driver.sv
// Issues an LFSR-generated burst of commands to a shifter, then checks that the
// shifter's operation counter advanced by exactly the number of non-NOP commands.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | one command per cycle from the LFSR, ops_left counts down
// CHECK | compare counter_in against base + nz_cnt, set sticky err on mismatch
// DONE  | one-cycle done pulse, start ignored, back to IDLE
module shifter_cmd_driver (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  num_ops,
  input  logic [7:0]                  seed,
  shifter_cmd_driver_if.master        sh,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] ops_left;
  logic [7:0] nz_cnt;
  logic [7:0] base;

  logic [7:0] seed_eff;
  logic [7:0] lfsr_nxt;
  logic [7:0] cnt_expected;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff     = (seed == 8'h00) ? 8'h01 : seed;
  assign lfsr_nxt     = lfsr_step(lfsr);
  assign cnt_expected = base + nz_cnt;

  // lfsr always holds the value of the command currently on the bus while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= 8'h01;
      ops_left   <= 8'h00;
      nz_cnt     <= 8'h00;
      base       <= 8'h00;
      sh.data_in <= 4'h0;
      sh.control <= 3'b000;
      sh.valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            err    <= 1'b0;
            nz_cnt <= 8'h00;
            busy   <= 1'b1;
            if (num_ops != 8'h00) begin
              state      <= RUN;
              ops_left   <= num_ops;
              lfsr       <= seed_eff;
              base       <= sh.counter_in;
              sh.data_in <= seed_eff[3:0];
              sh.control <= seed_eff[6:4];
              sh.valid   <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (sh.control != 3'b000) begin
            nz_cnt <= nz_cnt + 8'd1;
          end
          ops_left <= ops_left - 8'd1;
          lfsr     <= lfsr_nxt;
          if (ops_left == 8'd1) begin
            state      <= CHECK;
            sh.data_in <= 4'h0;
            sh.control <= 3'b000;
            sh.valid   <= 1'b0;
          end else begin
            sh.data_in <= lfsr_nxt[3:0];
            sh.control <= lfsr_nxt[6:4];
            sh.valid   <= 1'b1;
          end
        end

        CHECK: begin
          // counter_in already reflects the last command here (shifter lags by one cycle).
          if (sh.counter_in != cnt_expected) begin
            err <= 1'b1;
          end
          state <= DONE;
          done  <= 1'b1;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          sh.data_in <= 4'h0;
          sh.control <= 3'b000;
          sh.valid   <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
